regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port between the in-order pipeline writeback
//   and the long-latency load/store unit (LSU), which returns out of band.
//   LSU results are buffered in a small FIFO. Pipeline writeback has priority, with a

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter_wb_fifo.sv | 67 ++++++
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, the writeback request record and the onehot helper.
// Used by the arbiter, its result FIFO and the port interface.
package regfile_write_arbiter_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // x0 is hardwired, so it never contributes to the busy mask.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [ADDR_W-1:0] rd);
        rd_onehot = '0;
        if (rd != '0) begin
            rd_onehot[rd] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Pipeline WB, LSU return and register-file write signals of the arbiter.
// slave = arbiter side, master = the driving environment.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic                pipe_valid;
    logic [ADDR_W-1:0]   pipe_rd;
    logic [DATA_W-1:0]   pipe_data;
    logic                pipe_ready;
    logic                lsu_valid;
    logic [ADDR_W-1:0]   lsu_rd;
    logic [DATA_W-1:0]   lsu_data;
    logic                lsu_ready;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [NUM_REGS-1:0] busy_mask;

    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output pipe_ready, lsu_ready,
        output wr_en, wr_addr, wr_data, busy_mask
    );

    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  pipe_ready, lsu_ready,
        input  wr_en, wr_addr, wr_data, busy_mask
    );

endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Circular buffer of LSU results; push/pop take effect at the next edge, no bypass.
// Pushes are ignored when full and pops when empty; per-slot valid bits are exported.
module wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  wb_req_t               push_req_i,
    input  logic                  pop_i,
    output wb_req_t               head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH-1:0]      entry_vld_o,
    output wb_req_t [DEPTH-1:0]   entries_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    wb_req_t [DEPTH-1:0] mem_q;
    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
    logic                push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = &vld_q;
    assign empty_o     = ~|vld_q;
    assign push_ok     = push_i && !full_o;
    assign pop_ok      = pop_i && !empty_o;
    assign head_o      = mem_q[rd_ptr_q];
    assign entry_vld_o = vld_q;
    assign entries_o   = mem_q;

    always_comb begin
        vld_d = vld_q;
        if (pop_ok) begin
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push_ok) begin
            vld_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            vld_q <= vld_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_req_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline WB and buffered LSU results.
// Write issues one edge after winning; pipe stalls via pipe_ready, LSU via lsu_ready=!full.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    regfile_write_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    wb_req_t                 fifo_head;
    wb_req_t [BUF_DEPTH-1:0] fifo_entries;
    logic [BUF_DEPTH-1:0]    fifo_vld;
    logic                    fifo_full, fifo_empty;
    logic                    fifo_push, fifo_win, pipe_win, pipe_hazard;
    logic [NUM_REGS-1:0]     busy;

    logic                    wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]       wr_data_q, wr_data_d;
    logic [CNT_W-1:0]        starve_q, starve_d;

    assign fifo_push = bus.lsu_valid && !fifo_full;

    wb_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_req_i  ('{rd: bus.lsu_rd, data: bus.lsu_data}),
        .pop_i       (fifo_win),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .entry_vld_o (fifo_vld),
        .entries_o   (fifo_entries)
    );

    // Everything not yet retired to the register file: buffered results plus the write in flight.
    always_comb begin
        busy = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (fifo_vld[i]) begin
                busy = busy | rd_onehot(fifo_entries[i].rd);
            end
        end
        if (wr_en_q) begin
            busy = busy | rd_onehot(wr_addr_q);
        end
    end

    assign pipe_hazard = bus.pipe_valid && (bus.pipe_rd != '0) && busy[bus.pipe_rd];
    assign fifo_win    = !fifo_empty && ((starve_q == STARVE_LIM) || pipe_hazard || !bus.pipe_valid);
    assign pipe_win    = bus.pipe_valid && !fifo_win && !pipe_hazard;

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (fifo_win) begin
            wr_en_d   = (fifo_head.rd != '0);
            wr_addr_d = fifo_head.rd;
            wr_data_d = fifo_head.data;
        end else if (pipe_win) begin
            wr_en_d   = (bus.pipe_rd != '0);
            wr_addr_d = bus.pipe_rd;
            wr_data_d = bus.pipe_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || fifo_win) begin
            starve_d = '0;
        end else if (pipe_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            starve_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.pipe_ready = !fifo_win && !pipe_hazard;
    assign bus.lsu_ready  = !fifo_full;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy_mask  = busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (BUF_DEPTH=2, STARVE_MAX=4).
// Each vector row holds inputs and all outputs observed with those inputs applied.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_write_arbiter_if rif();

    regfile_write_arbiter #(.BUF_DEPTH(2), .STARVE_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (rif)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        e_pr;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_bm;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic e_pr, input logic e_lr, input logic e_we,
                       input logic [4:0] e_wa, input logic [31:0] e_wd, input logic [31:0] e_bm);
        vec_t v;
        v.pv = pv;     v.prd = prd;   v.pd = pd;
        v.lv = lv;     v.lrd = lrd;   v.ld = ld;
        v.e_pr = e_pr; v.e_lr = e_lr; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_bm = e_bm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        rif.pipe_valid = pv;
        rif.pipe_rd    = prd;
        rif.pipe_data  = pd;
        rif.lsu_valid  = lv;
        rif.lsu_rd     = lrd;
        rif.lsu_data   = ld;
    endtask

    task automatic check_outputs(input string tag, input logic e_pr, input logic e_lr,
                                 input logic e_we, input logic [4:0] e_wa,
                                 input logic [31:0] e_wd, input logic [31:0] e_bm);
        check({tag, " pipe_ready"}, {31'd0, rif.pipe_ready}, {31'd0, e_pr});
        check({tag, " lsu_ready"},  {31'd0, rif.lsu_ready},  {31'd0, e_lr});
        check({tag, " wr_en"},      {31'd0, rif.wr_en},      {31'd0, e_we});
        check({tag, " wr_addr"},    {27'd0, rif.wr_addr},    {27'd0, e_wa});
        check({tag, " wr_data"},    rif.wr_data,             e_wd);
        check({tag, " busy_mask"},  rif.busy_mask,           e_bm);
    endtask

    initial begin
        //   pv prd pd          lv lrd ld          pr lr we wa wd          bm
        // Pipe streaming x3/x4 with an empty FIFO: full rate, pipe_ready high.
        add(1, 3, 32'hA5,      0, 0, 0,          1, 1, 0, 0, 32'h0,      32'h0);
        add(1, 4, 32'hB6,      0, 0, 0,          1, 1, 1, 3, 32'hA5,     32'h8);
        // LSU x7 arrives; pipe keeps winning for four cycles, then FIFO is forced through.
        add(1, 3, 32'hA5,      1, 7, 32'h11,     1, 1, 1, 4, 32'hB6,     32'h10);
        add(1, 4, 32'hB6,      0, 0, 0,          1, 1, 1, 3, 32'hA5,     32'h88);
        add(1, 3, 32'hA5,      0, 0, 0,          1, 1, 1, 4, 32'hB6,     32'h90);
        add(1, 4, 32'hB6,      0, 0, 0,          1, 1, 1, 3, 32'hA5,     32'h88);
        add(1, 3, 32'hA5,      0, 0, 0,          1, 1, 1, 4, 32'hB6,     32'h90);
        add(1, 4, 32'hB6,      0, 0, 0,          0, 1, 1, 3, 32'hA5,     32'h88);
        add(1, 4, 32'hB6,      0, 0, 0,          1, 1, 1, 7, 32'h11,     32'h80);
        // WAW on x9: LSU write issues and retires before the pipe write of x9.
        add(0, 0, 0,           1, 9, 32'h99,     1, 1, 1, 4, 32'hB6,     32'h10);
        add(1, 9, 32'h55,      0, 0, 0,          0, 1, 0, 4, 32'hB6,     32'h200);
        add(1, 9, 32'h55,      0, 0, 0,          0, 1, 1, 9, 32'h99,     32'h200);
        add(1, 9, 32'h55,      0, 0, 0,          1, 1, 0, 9, 32'h99,     32'h0);
        add(0, 0, 0,           0, 0, 0,          1, 1, 1, 9, 32'h55,     32'h200);
        // Fill the FIFO under pipe load, then drain with push+pop in one cycle.
        add(1, 1, 32'h01,      1, 5, 32'h50,     1, 1, 0, 9, 32'h55,     32'h0);
        add(1, 2, 32'h02,      1, 6, 32'h60,     1, 1, 1, 1, 32'h01,     32'h22);
        add(1, 1, 32'h01,      1, 8, 32'h80,     1, 0, 1, 2, 32'h02,     32'h64);
        add(1, 2, 32'h02,      1, 8, 32'h80,     1, 0, 1, 1, 32'h01,     32'h62);
        add(0, 0, 0,           1, 8, 32'h80,     0, 0, 1, 2, 32'h02,     32'h64);
        add(0, 0, 0,           1, 8, 32'h80,     0, 1, 1, 5, 32'h50,     32'h60);
        add(0, 0, 0,           0, 0, 0,          0, 1, 1, 6, 32'h60,     32'h140);
        add(0, 0, 0,           0, 0, 0,          1, 1, 1, 8, 32'h80,     32'h100);
        // x0 results are consumed but never written.
        add(1, 0, 32'hDEAD,    1, 0, 32'hBEEF,   1, 1, 0, 8, 32'h80,     32'h0);
        add(0, 0, 0,           0, 0, 0,          0, 1, 0, 0, 32'hDEAD,   32'h0);
        add(0, 0, 0,           0, 0, 0,          1, 1, 0, 0, 32'hBEEF,   32'h0);

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_outputs("reset", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            drive(vecs[i].pv, vecs[i].prd, vecs[i].pd, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_pr, vecs[i].e_lr, vecs[i].e_we,
                          vecs[i].e_wa, vecs[i].e_wd, vecs[i].e_bm);
        end

        // Reset with x5/x6 buffered: both must be dropped, never written.
        @(negedge clock);
        drive(1, 1, 32'h1, 1, 5, 32'h55);
        @(negedge clock);
        drive(1, 2, 32'h2, 1, 6, 32'h66);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("prefill busy_mask", rif.busy_mask, 32'h64);
        check("prefill lsu_ready", {31'd0, rif.lsu_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_outputs("midreset", 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("postreset%0d wr_en", i), {31'd0, rif.wr_en}, 32'd0);
            check($sformatf("postreset%0d busy_mask", i), rif.busy_mask, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
